// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path definitions: default reset PC, entry width and pointer-width helper.
// Optional feature macro used by the fetch unit: FETCH_PERF_CNT_EN.
`ifndef PC_START
`define PC_START 64'h0000_0000_8000_0000
`endif

package fetch_unit_pkg;

    localparam int unsigned FETCH_XLEN    = 64;
    localparam int unsigned FETCH_ILEN    = 32;
    localparam int unsigned FETCH_ENTRY_W = FETCH_XLEN + FETCH_ILEN;

    // One extra bit over the index lets full and empty be told apart.
    function automatic int unsigned fqPtrWidth(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// Three-pointer fetch queue: entries are allocated with a PC at request time (tail),
// filled with an instruction on response (fill) and consumed by decode (head).
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ILEN    = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ENTRY_W = FETCH_ENTRY_W,
    parameter int unsigned PW      = fqPtrWidth(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               alloc_i,
    input  logic [XLEN-1:0]    allocPc_i,
    input  logic               fill_i,
    input  logic [ILEN-1:0]    fillData_i,
    input  logic               pop_i,
    output logic               headValid_o,
    output logic [ENTRY_W-1:0] headEntry_o,
    output logic [PW-1:0]      count_o,
    output logic [PW-1:0]      inflight_o
);

    localparam int unsigned IW = $clog2(DEPTH);

    logic [PW-1:0]      headPtr_q, headPtr_d;
    logic [PW-1:0]      fillPtr_q, fillPtr_d;
    logic [PW-1:0]      tailPtr_q, tailPtr_d;
    logic [ENTRY_W-1:0] entryMem_q [DEPTH];

    // A flush collapses all three pointers onto the tail and voids any same-cycle update.
    always_comb begin
        headPtr_d = headPtr_q;
        fillPtr_d = fillPtr_q;
        tailPtr_d = tailPtr_q;
        if (flush_i) begin
            headPtr_d = tailPtr_q;
            fillPtr_d = tailPtr_q;
        end else begin
            if (alloc_i) tailPtr_d = tailPtr_q + PW'(1);
            if (fill_i)  fillPtr_d = fillPtr_q + PW'(1);
            if (pop_i)   headPtr_d = headPtr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            headPtr_q <= '0;
            fillPtr_q <= '0;
            tailPtr_q <= '0;
        end else begin
            headPtr_q <= headPtr_d;
            fillPtr_q <= fillPtr_d;
            tailPtr_q <= tailPtr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_i && !flush_i) entryMem_q[tailPtr_q[IW-1:0]][ENTRY_W-1 -: XLEN] <= allocPc_i;
        if (fill_i && !flush_i)  entryMem_q[fillPtr_q[IW-1:0]][ILEN-1:0] <= fillData_i;
    end

    assign headValid_o = (headPtr_q != fillPtr_q);
    assign headEntry_o = entryMem_q[headPtr_q[IW-1:0]];
    assign count_o     = tailPtr_q - headPtr_q;
    assign inflight_o  = tailPtr_q - fillPtr_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: sequential PC generation, credit-limited imem requests, redirect flush with
// stale-response dropping. Perf counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = `PC_START,
    parameter int unsigned     FQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_redir_en,
    input  logic [XLEN-1:0] pc_redir,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_inst,
    output logic [31:0]     perf_redir_cnt,
    output logic [31:0]     perf_stall_cnt
);

    localparam int unsigned     PW      = fqPtrWidth(FQ_DEPTH);
    localparam int unsigned     ENTRY_W = XLEN + ILEN;
    localparam logic [XLEN-1:0] PC_INC  = XLEN'(ILEN / 8);

    logic [XLEN-1:0]    fetchPc_q, fetchPc_d;
    logic [PW-1:0]      dropCnt_q, dropCnt_d;
    logic [PW-1:0]      count, inflight;
    logic [PW:0]        creditUse;
    logic               reqFire, rspFill, popFire;
    logic [ENTRY_W-1:0] headEntry;

    assign creditUse      = {1'b0, count} + {1'b0, dropCnt_q};
    assign imem_req_valid = !rst && !pc_redir_en && (creditUse < (PW+1)'(FQ_DEPTH));
    assign imem_req_addr  = fetchPc_q;
    assign reqFire        = imem_req_valid && imem_req_ready;
    assign rspFill        = imem_rsp_valid && (dropCnt_q == '0) && !pc_redir_en;
    assign popFire        = out_valid && out_ready;

    fetch_queue #(
        .XLEN    (XLEN),
        .ILEN    (ILEN),
        .DEPTH   (FQ_DEPTH),
        .ENTRY_W (ENTRY_W),
        .PW      (PW)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (pc_redir_en),
        .alloc_i     (reqFire),
        .allocPc_i   (fetchPc_q),
        .fill_i      (rspFill),
        .fillData_i  (imem_rsp_data),
        .pop_i       (popFire),
        .headValid_o (out_valid),
        .headEntry_o (headEntry),
        .count_o     (count),
        .inflight_o  (inflight)
    );

    assign out_pc   = headEntry[ENTRY_W-1 -: XLEN];
    assign out_inst = headEntry[ILEN-1:0];

    // On redirect every unfilled entry becomes a response to drop; a response arriving in the
    // redirect cycle is itself discarded, so it consumes one of those pending drops.
    always_comb begin
        fetchPc_d = fetchPc_q;
        dropCnt_d = dropCnt_q;
        if (pc_redir_en) begin
            fetchPc_d = pc_redir & ~XLEN'(3);
            dropCnt_d = dropCnt_q + inflight - PW'(imem_rsp_valid);
        end else begin
            if (reqFire) fetchPc_d = fetchPc_q + PC_INC;
            if (imem_rsp_valid && (dropCnt_q != '0)) dropCnt_d = dropCnt_q - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc_q <= PC_RESET;
            dropCnt_q <= '0;
        end else begin
            fetchPc_q <= fetchPc_d;
            dropCnt_q <= dropCnt_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perfRedir_q, perfStall_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            perfRedir_q <= '0;
            perfStall_q <= '0;
        end else begin
            if (pc_redir_en && (perfRedir_q != '1))             perfRedir_q <= perfRedir_q + 32'd1;
            if (out_valid && !out_ready && (perfStall_q != '1)) perfStall_q <= perfStall_q + 32'd1;
        end
    end

    assign perf_redir_cnt = perfRedir_q;
    assign perf_stall_cnt = perfStall_q;
`else
    assign perf_redir_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency in-order instruction memory model.
module tb_fetch_unit;

    localparam logic [31:0] INST_KEY = 32'h1357_9BDF;

    typedef struct {
        int          due;
        logic [63:0] addr;
    } memReq_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_redir_en = 1'b0;
    logic [63:0] pc_redir = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] perf_redir_cnt;
    logic [31:0] perf_stall_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int memLat = 1;
    memReq_t memQ[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .pc_redir_en    (pc_redir_en),
        .pc_redir       (pc_redir),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .perf_redir_cnt (perf_redir_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    function automatic logic [31:0] instOf(input logic [63:0] pc);
        return pc[31:0] ^ INST_KEY;
    endfunction

    // Memory model: records accepted requests, retires the response it presented.
    always @(posedge clk) begin
        if (rst) begin
            memQ.delete();
        end else begin
            if (imem_rsp_valid && memQ.size() > 0) void'(memQ.pop_front());
            if (imem_req_valid && imem_req_ready) memQ.push_back('{due: cyc + memLat, addr: imem_req_addr});
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (!rst && memQ.size() > 0 && memQ[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instOf(memQ[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic doReset(input int lat, input logic ready);
        @(negedge clk);
        rst = 1'b1;
        pc_redir_en = 1'b0;
        out_ready = ready;
        memLat = lat;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic waitOutValid(input string name, input int bound);
        bit seen = 0;
        for (int i = 0; i < bound; i++) begin
            if (out_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s: out_valid got 0 within %0d cycles, expected 1", name, bound);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        memLat = 1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_req_valid: got %b expected 0", imem_req_valid);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (imem_req_addr !== 64'h8000_0000) begin
            errors++;
            $display("[TB] FAIL reset_addr: got %h expected %h", imem_req_addr, 64'h8000_0000);
        end
        checks++;
        if (perf_redir_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_perf: got %0d/%0d expected 0/0", perf_redir_cnt, perf_stall_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_req_valid: got %b expected 1", imem_req_valid);
        end
    endtask

    task automatic test_sequential();
        logic [63:0] expPc;
        doReset(1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            expPc = 64'h8000_0000 + 64'(4 * i);
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== expPc) begin
                errors++;
                $display("[TB] FAIL seq_req[%0d]: got %b/%h expected 1/%h", i, imem_req_valid, imem_req_addr, expPc);
            end
            checks++;
            if (i < 2) begin
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL seq_early_valid[%0d]: got %b expected 0", i, out_valid);
                end
            end else begin
                expPc = 64'h8000_0000 + 64'(4 * (i - 2));
                if (out_valid !== 1'b1 || out_pc !== expPc || out_inst !== instOf(expPc)) begin
                    errors++;
                    $display("[TB] FAIL seq_out[%0d]: got %b/%h/%h expected 1/%h/%h", i, out_valid, out_pc, out_inst, expPc, instOf(expPc));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        int reqCnt = 0;
        logic [63:0] expPc;
        doReset(1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (imem_req_valid) reqCnt++;
            if (i >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000) begin
                    errors++;
                    $display("[TB] FAIL stall_hold[%0d]: got %b/%h expected 1/%h", i, out_valid, out_pc, 64'h8000_0000);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (reqCnt !== 4) begin
            errors++;
            $display("[TB] FAIL stall_req_count: got %0d expected 4", reqCnt);
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_full_valid: got %b expected 0", imem_req_valid);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expPc = 64'h8000_0000 + 64'(4 * k);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== expPc || out_inst !== instOf(expPc)) begin
                errors++;
                $display("[TB] FAIL stall_drain[%0d]: got %b/%h/%h expected 1/%h/%h", k, out_valid, out_pc, out_inst, expPc, instOf(expPc));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        doReset(3, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (imem_req_addr !== 64'h8000_000C) begin
            errors++;
            $display("[TB] FAIL redir_pre_addr: got %h expected %h", imem_req_addr, 64'h8000_000C);
        end
        pc_redir_en = 1'b1;
        pc_redir = 64'h8000_1002;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL redir_req_valid: got %b expected 0", imem_req_valid);
        end
        @(negedge clk);
        pc_redir_en = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_1000) begin
            errors++;
            $display("[TB] FAIL redir_new_req: got %b/%h expected 1/%h", imem_req_valid, imem_req_addr, 64'h8000_1000);
        end
        waitOutValid("redir_wait", 20);
        checks++;
        if (out_pc !== 64'h8000_1000 || out_inst !== instOf(64'h8000_1000)) begin
            errors++;
            $display("[TB] FAIL redir_first_out: got %h/%h expected %h/%h", out_pc, out_inst, 64'h8000_1000, instOf(64'h8000_1000));
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h8000_1004 || out_inst !== instOf(64'h8000_1004)) begin
            errors++;
            $display("[TB] FAIL redir_second_out: got %b/%h/%h expected 1/%h/%h", out_valid, out_pc, out_inst, 64'h8000_1004, instOf(64'h8000_1004));
        end
    endtask

    task automatic test_redirect_pop();
        doReset(2, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h8000_0008) begin
            errors++;
            $display("[TB] FAIL rpop_pre: got %b/%h expected 1/%h", out_valid, out_pc, 64'h8000_0008);
        end
        pc_redir_en = 1'b1;
        pc_redir = 64'h8000_2000;
        @(negedge clk);
        pc_redir_en = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rpop_flushed: got %b expected 0", out_valid);
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_2000) begin
            errors++;
            $display("[TB] FAIL rpop_new_req: got %b/%h expected 1/%h", imem_req_valid, imem_req_addr, 64'h8000_2000);
        end
        waitOutValid("rpop_wait", 20);
        checks++;
        if (out_pc !== 64'h8000_2000 || out_inst !== instOf(64'h8000_2000)) begin
            errors++;
            $display("[TB] FAIL rpop_first_out: got %h/%h expected %h/%h", out_pc, out_inst, 64'h8000_2000, instOf(64'h8000_2000));
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] expPc;
        doReset(2, 1'b1);
        repeat (5) @(negedge clk);
        pc_redir_en = 1'b1;
        pc_redir = 64'h0000_0100;
        @(negedge clk);
        pc_redir = 64'h0000_0200;
        @(negedge clk);
        pc_redir_en = 1'b0;
        waitOutValid("b2b_wait", 20);
        for (int k = 0; k < 4; k++) begin
            expPc = 64'h0000_0200 + 64'(4 * k);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== expPc || out_inst !== instOf(expPc)) begin
                errors++;
                $display("[TB] FAIL b2b_out[%0d]: got %b/%h/%h expected 1/%h/%h", k, out_valid, out_pc, out_inst, expPc, instOf(expPc));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_perf();
        logic [31:0] expRedir, expStall;
`ifdef FETCH_PERF_CNT_EN
        expRedir = 32'd5;
        expStall = 32'd7;
`else
        expRedir = 32'd0;
        expStall = 32'd0;
`endif
        doReset(1, 1'b0);
        for (int r = 0; r < 5; r++) begin
            pc_redir_en = 1'b1;
            pc_redir = 64'h0000_0400 + 64'(16 * r);
            @(negedge clk);
        end
        pc_redir_en = 1'b0;
        waitOutValid("perf_wait", 20);
        repeat (7) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (perf_redir_cnt !== expRedir) begin
            errors++;
            $display("[TB] FAIL perf_redir: got %0d expected %0d", perf_redir_cnt, expRedir);
        end
        checks++;
        if (perf_stall_cnt !== expStall) begin
            errors++;
            $display("[TB] FAIL perf_stall: got %0d expected %0d", perf_stall_cnt, expStall);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_pop();
        test_back_to_back();
        test_perf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
